m_pte_responder: RTL and testbench

- Responder side of the page-walker PTE port: accepts single-word PTE read and write (A/D update) requests from the MMU page walker and executes them against the DRAM controller port.
- Returns read data and a busy indication in the same style the walker already polls (busy/odata).
- Holds a one-entry last-PTE buffer so repeated L1 reads within a walk burst skip DRAM.
- Sits between the MMU and the DRAM arbiter inside the CPU memory subsystem.

---
 rtl/m_pte_responder.sv | 104 ++++++++++
 tb/tb_m_pte_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/m_pte_responder.sv
// m_pte_responder: executes page-walker PTE reads/writes against DRAM,
// with a one-entry last-PTE buffer that short-circuits repeated reads.
module m_pte_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter bit ENABLE_BUF = 1
) (
   input  logic                  CLK,
   input  logic                  RST_X,
   input  logic                  w_pte_req,
   input  logic                  w_pte_we,
   input  logic [ADDR_WIDTH-1:0] w_pte_addr,
   input  logic [31:0]           w_pte_wdata,
   input  logic                  w_flush,
   output logic                  w_pte_busy,
   output logic [31:0]           w_pte_odata,
   output logic                  w_pte_rvalid,
   output logic                  w_pte_err,
   output logic                  w_dram_req,
   output logic                  w_dram_we,
   output logic [ADDR_WIDTH-1:0] w_dram_addr,
   output logic [31:0]           w_dram_wdata,
   input  logic                  w_dram_ack,
   input  logic                  w_dram_rvalid,
   input  logic [31:0]           w_dram_rdata
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, DONE} state_t;
   state_t                state_q;
   logic                  we_q, mis_q, fill_q, rvalid_q, err_q, req_q, bvalid_q;
   logic [ADDR_WIDTH-1:0] addr_q, baddr_q;
   logic [31:0]           wdata_q, odata_q, bdata_q;
   logic                  mis, hit;
   assign mis = w_pte_addr[1:0] != 2'b00;
   assign hit = ENABLE_BUF && !w_pte_we && bvalid_q && !w_flush && baddr_q == w_pte_addr;
   assign w_pte_busy   = state_q != IDLE;
   assign w_pte_odata  = odata_q;
   assign w_pte_rvalid = rvalid_q;
   assign w_pte_err    = err_q;
   assign w_dram_req   = req_q;
   assign w_dram_we    = we_q;
   assign w_dram_addr  = addr_q;
   assign w_dram_wdata = wdata_q;
   // fill_q remembers whether a flush hit this read while in flight, so it must not fill
   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         mis_q    <= 1'b0;
         fill_q   <= 1'b0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         req_q    <= 1'b0;
         bvalid_q <= 1'b0;
         addr_q   <= '0;
         baddr_q  <= '0;
         wdata_q  <= '0;
         odata_q  <= '0;
         bdata_q  <= '0;
      end else begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         if (w_flush) begin
            bvalid_q <= 1'b0;
            fill_q   <= 1'b0;
         end
         case (state_q)
            IDLE: if (w_pte_req) begin
               we_q    <= w_pte_we;
               addr_q  <= w_pte_addr;
               wdata_q <= w_pte_wdata;
               mis_q   <= mis;
               fill_q  <= ENABLE_BUF && !w_flush;
               if (mis) state_q <= DONE;
               else if (hit) begin
                  odata_q <= bdata_q;
                  state_q <= DONE;
               end else begin
                  req_q   <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            ISSUE: if (w_dram_ack) begin
               req_q   <= 1'b0;
               state_q <= we_q ? DONE : WAIT_R;
               if (ENABLE_BUF && we_q && addr_q == baddr_q) bdata_q <= wdata_q;
            end
            WAIT_R: if (w_dram_rvalid) begin
               odata_q <= w_dram_rdata;
               state_q <= DONE;
               if (fill_q && !w_flush) begin
                  bvalid_q <= 1'b1;
                  baddr_q  <= addr_q;
                  bdata_q  <= w_dram_rdata;
               end
            end
            DONE: begin
               rvalid_q <= 1'b1;
               err_q    <= mis_q;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_m_pte_responder.sv
// tb_m_pte_responder: directed checks of miss, hit, write-through, flush,
// misalignment and mid-operation reset with hand-computed expectations.
module tb_m_pte_responder;
   logic        CLK = 1'b0;
   logic        RST_X = 1'b0;
   logic        w_pte_req = 1'b0, w_pte_we = 1'b0, w_flush = 1'b0;
   logic [31:0] w_pte_addr = '0, w_pte_wdata = '0;
   logic        w_pte_busy, w_pte_rvalid, w_pte_err;
   logic [31:0] w_pte_odata;
   logic        w_dram_req, w_dram_we;
   logic [31:0] w_dram_addr, w_dram_wdata;
   logic        w_dram_ack = 1'b0, w_dram_rvalid = 1'b0;
   logic [31:0] w_dram_rdata = '0;
   int          errors = 0, checks = 0;

   m_pte_responder #(.ADDR_WIDTH(32), .ENABLE_BUF(1'b1)) dut (
      .CLK(CLK), .RST_X(RST_X),
      .w_pte_req(w_pte_req), .w_pte_we(w_pte_we), .w_pte_addr(w_pte_addr),
      .w_pte_wdata(w_pte_wdata), .w_flush(w_flush),
      .w_pte_busy(w_pte_busy), .w_pte_odata(w_pte_odata),
      .w_pte_rvalid(w_pte_rvalid), .w_pte_err(w_pte_err),
      .w_dram_req(w_dram_req), .w_dram_we(w_dram_we), .w_dram_addr(w_dram_addr),
      .w_dram_wdata(w_dram_wdata), .w_dram_ack(w_dram_ack),
      .w_dram_rvalid(w_dram_rvalid), .w_dram_rdata(w_dram_rdata)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      w_pte_req = 1'b1; w_pte_we = we; w_pte_addr = addr; w_pte_wdata = wd;
      step();
      w_pte_req = 1'b0;
   endtask

   initial begin
      step(); step();
      chk("rst_busy", 32'(w_pte_busy), 0);
      chk("rst_rvalid", 32'(w_pte_rvalid), 0);
      chk("rst_err", 32'(w_pte_err), 0);
      chk("rst_dreq", 32'(w_dram_req), 0);
      chk("rst_dwe", 32'(w_dram_we), 0);
      chk("rst_daddr", w_dram_addr, 0);
      chk("rst_dwdata", w_dram_wdata, 0);
      chk("rst_odata", w_pte_odata, 0);
      RST_X = 1'b1;
      step();
      // read miss
      issue_req(1'b0, 32'h0080_1004, 32'h0);
      chk("miss_busy1", 32'(w_pte_busy), 1);
      chk("miss_dreq", 32'(w_dram_req), 1);
      chk("miss_daddr", w_dram_addr, 32'h0080_1004);
      chk("miss_dwe", 32'(w_dram_we), 0);
      w_dram_ack = 1'b1;
      step();
      w_dram_ack = 1'b0;
      chk("miss_dreq_drop", 32'(w_dram_req), 0);
      chk("miss_busy2", 32'(w_pte_busy), 1);
      step();
      chk("miss_busy3", 32'(w_pte_busy), 1);
      w_dram_rvalid = 1'b1; w_dram_rdata = 32'h2000_04CF;
      step();
      w_dram_rvalid = 1'b0; w_dram_rdata = 32'h0;
      chk("miss_busy4", 32'(w_pte_busy), 1);
      chk("miss_rv_early", 32'(w_pte_rvalid), 0);
      step();
      chk("miss_rvalid", 32'(w_pte_rvalid), 1);
      chk("miss_odata", w_pte_odata, 32'h2000_04CF);
      chk("miss_err", 32'(w_pte_err), 0);
      step();
      chk("miss_rv_pulse", 32'(w_pte_rvalid), 0);
      chk("miss_odata_hold", w_pte_odata, 32'h2000_04CF);
      // buffer hit
      issue_req(1'b0, 32'h0080_1004, 32'h0);
      chk("hit_busy", 32'(w_pte_busy), 1);
      chk("hit_dreq", 32'(w_dram_req), 0);
      step();
      chk("hit_rvalid", 32'(w_pte_rvalid), 1);
      chk("hit_dreq2", 32'(w_dram_req), 0);
      chk("hit_odata", w_pte_odata, 32'h2000_04CF);
      // write with three stall cycles, plus an ignored request while busy
      issue_req(1'b1, 32'h0080_1004, 32'h2000_04CF | 32'hC0);
      chk("wr_dreq1", 32'(w_dram_req), 1);
      chk("wr_dwe", 32'(w_dram_we), 1);
      chk("wr_dwdata1", w_dram_wdata, 32'h2000_04CF);
      w_pte_req = 1'b1; w_pte_we = 1'b0; w_pte_addr = 32'h0000_0100;
      step();
      w_pte_req = 1'b0;
      chk("wr_dreq2", 32'(w_dram_req), 1);
      chk("wr_daddr2", w_dram_addr, 32'h0080_1004);
      chk("wr_dwe2", 32'(w_dram_we), 1);
      step();
      chk("wr_dreq3", 32'(w_dram_req), 1);
      chk("wr_dwdata3", w_dram_wdata, 32'h2000_04CF);
      w_dram_ack = 1'b1;
      step();
      w_dram_ack = 1'b0;
      chk("wr_dreq_drop", 32'(w_dram_req), 0);
      chk("wr_rv_early", 32'(w_pte_rvalid), 0);
      step();
      chk("wr_rvalid", 32'(w_pte_rvalid), 1);
      chk("wr_err", 32'(w_pte_err), 0);
      step();
      chk("wr_rv_pulse", 32'(w_pte_rvalid), 0);
      issue_req(1'b0, 32'h0080_1004, 32'h0);
      chk("wrhit_dreq", 32'(w_dram_req), 0);
      step();
      chk("wrhit_rvalid", 32'(w_pte_rvalid), 1);
      chk("wrhit_odata", w_pte_odata, 32'h2000_04CF);
      // write-through with a new value updates the buffer, leaves odata alone
      issue_req(1'b1, 32'h0080_1004, 32'h2000_04EF);
      w_dram_ack = 1'b1;
      step();
      w_dram_ack = 1'b0;
      step();
      chk("wr2_rvalid", 32'(w_pte_rvalid), 1);
      chk("wr2_odata", w_pte_odata, 32'h2000_04CF);
      issue_req(1'b0, 32'h0080_1004, 32'h0);
      chk("wr2hit_dreq", 32'(w_dram_req), 0);
      step();
      chk("wr2hit_odata", w_pte_odata, 32'h2000_04EF);
      // flush during WAIT_R: read completes, buffer not filled
      issue_req(1'b0, 32'h0080_1008, 32'h0);
      chk("fl_dreq", 32'(w_dram_req), 1);
      w_dram_ack = 1'b1;
      step();
      w_dram_ack = 1'b0; w_flush = 1'b1;
      step();
      w_flush = 1'b0; w_dram_rvalid = 1'b1; w_dram_rdata = 32'hAAAA_0001;
      step();
      w_dram_rvalid = 1'b0;
      step();
      chk("fl_rvalid", 32'(w_pte_rvalid), 1);
      chk("fl_odata", w_pte_odata, 32'hAAAA_0001);
      issue_req(1'b0, 32'h0080_1008, 32'h0);
      chk("fl_refetch_dreq", 32'(w_dram_req), 1);
      w_dram_ack = 1'b1;
      step();
      w_dram_ack = 1'b0; w_dram_rvalid = 1'b1; w_dram_rdata = 32'hBBBB_0002;
      step();
      w_dram_rvalid = 1'b0;
      step();
      chk("fl_refetch_odata", w_pte_odata, 32'hBBBB_0002);
      // flushed buffer: earlier address must miss now
      issue_req(1'b0, 32'h0080_1004, 32'h0);
      chk("fl_oldaddr_dreq", 32'(w_dram_req), 1);
      w_dram_ack = 1'b1;
      step();
      w_dram_ack = 1'b0; w_dram_rvalid = 1'b1; w_dram_rdata = 32'h2000_04EF;
      step();
      w_dram_rvalid = 1'b0;
      step();
      chk("fl_oldaddr_odata", w_pte_odata, 32'h2000_04EF);
      // misaligned
      issue_req(1'b0, 32'h0080_1006, 32'h0);
      chk("mis_dreq", 32'(w_dram_req), 0);
      chk("mis_busy", 32'(w_pte_busy), 1);
      step();
      chk("mis_rvalid", 32'(w_pte_rvalid), 1);
      chk("mis_err", 32'(w_pte_err), 1);
      chk("mis_odata", w_pte_odata, 32'h2000_04EF);
      step();
      chk("mis_err_pulse", 32'(w_pte_err), 0);
      // reset during ISSUE
      issue_req(1'b0, 32'h0080_100C, 32'h0);
      chk("rs_dreq", 32'(w_dram_req), 1);
      RST_X = 1'b0;
      step();
      RST_X = 1'b1;
      chk("rs_dreq_drop", 32'(w_dram_req), 0);
      chk("rs_busy", 32'(w_pte_busy), 0);
      w_dram_rvalid = 1'b1; w_dram_ack = 1'b1; w_dram_rdata = 32'hDEAD_BEEF;
      step();
      w_dram_rvalid = 1'b0; w_dram_ack = 1'b0;
      chk("rs_late_rvalid", 32'(w_pte_rvalid), 0);
      step();
      chk("rs_late_rvalid2", 32'(w_pte_rvalid), 0);
      chk("rs_late_odata", w_pte_odata, 32'h0);
      issue_req(1'b0, 32'h0080_1004, 32'h0);
      chk("rs_buf_cleared", 32'(w_dram_req), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
